router_pkt_fifo: RTL and testbench

- Parametrised output-channel packet FIFO for the router. It is the next generation of the per-port FIFO.
- It stores words tagged with start-of-packet (SOP) and end-of-packet (EOP) flags, and keeps a count of complete packets.
- It supports two modes: cut-through, and store-and-forward (vld_out asserted only once a whole packet is stored).
- It has a programmable read timeout. On expiry it flushes the FIFO and reports the event to the controller.
- There is one instance per router output port, between the register block and the output pins.

---
 rtl/router_pkt_fifo_if.sv | 37 +++
 rtl/router_pkt_fifo.sv | 134 +++++++++++++
 tb/tb_router_pkt_fifo.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/router_pkt_fifo_if.sv
// rtl/router_pkt_fifo_if.sv - write/read/status bundle between the controller and one output-port FIFO
interface router_pkt_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              soft_rst;
  logic              write_enb;
  logic              wr_sop;
  logic              wr_eop;
  logic [DATA_W-1:0] data_in;
  logic              full;
  logic              almost_full;
  logic              overflow;
  logic              read_enb;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              rd_sop;
  logic              rd_eop;
  logic              vld_out;
  logic              empty;
  logic [CW-1:0]     pkt_count;
  logic              timeout_flush;

  modport master (
    output soft_rst, write_enb, wr_sop, wr_eop, data_in, read_enb,
    input  full, almost_full, overflow, data_out, rd_valid, rd_sop, rd_eop,
           vld_out, empty, pkt_count, timeout_flush
  );

  modport slave (
    input  soft_rst, write_enb, wr_sop, wr_eop, data_in, read_enb,
    output full, almost_full, overflow, data_out, rd_valid, rd_sop, rd_eop,
           vld_out, empty, pkt_count, timeout_flush
  );
endinterface

// File: rtl/router_pkt_fifo.sv
// rtl/router_pkt_fifo.sv - output-port packet FIFO with cut-through/store-and-forward and read timeout flush
module router_pkt_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int MODE      = 0,
  parameter int TIMEOUT   = 30,
  parameter int AF_THRESH = 14
) (
  input  logic              clk,
  input  logic              resetn,
  router_pkt_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int MW = DATA_W + 2;

  logic [MW-1:0]     mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     pkt_cnt_q, pkt_cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rd_valid_q, rd_valid_d, rd_sop_q, rd_sop_d, rd_eop_q, rd_eop_d;
  logic              overflow_q, overflow_d, tflush_q, tflush_d;
  logic              drop_q, drop_d, in_pkt_q, in_pkt_d;

  logic              full, empty, vld, stall, timeout_hit, flush;
  logic              rd_accept, wr_room, wr_accept, pkt_inc, pkt_dec;
  logic [AW:0]       occupancy;
  logic [MW-1:0]     rd_word;

  assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign occupancy   = wr_ptr_q - rd_ptr_q;
  assign vld         = (MODE == 0) ? !empty : (pkt_cnt_q != '0);
  assign stall       = vld && !bus.read_enb;
  assign timeout_hit = stall && (timer_q == TW'(TIMEOUT - 1));
  assign flush       = bus.soft_rst || timeout_hit;
  assign rd_word     = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_accept   = bus.read_enb && !empty && ((MODE == 0) || (pkt_cnt_q != '0)) && !flush;
  // A pop in the same cycle frees the slot, so a full FIFO still takes a write alongside a read.
  assign wr_room     = !full || rd_accept;
  assign wr_accept   = bus.write_enb && wr_room && (!drop_q || bus.wr_sop) && !flush;
  assign pkt_inc     = wr_accept && bus.wr_eop;
  assign pkt_dec     = rd_accept && rd_word[MW-2] && (pkt_cnt_q != '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pkt_cnt_d  = pkt_cnt_q;
    timer_d    = timer_q;
    dout_d     = dout_q;
    rd_sop_d   = rd_sop_q;
    rd_eop_d   = rd_eop_q;
    drop_d     = drop_q;
    in_pkt_d   = in_pkt_q;
    rd_valid_d = rd_accept;
    overflow_d = bus.write_enb && !wr_room;
    tflush_d   = timeout_hit;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      pkt_cnt_d = '0;
      timer_d   = '0;
      dout_d    = '0;
      rd_sop_d  = 1'b0;
      rd_eop_d  = 1'b0;
      // The writer is still mid-packet: discard its tail until the next header.
      drop_d    = drop_q || in_pkt_q;
      in_pkt_d  = 1'b0;
    end else begin
      timer_d = stall ? timer_q + 1'b1 : '0;
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        drop_d   = 1'b0;
        in_pkt_d = !bus.wr_eop;
      end
      if (rd_accept) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        dout_d   = rd_word[DATA_W-1:0];
        rd_sop_d = rd_word[MW-1];
        rd_eop_d = rd_word[MW-2];
      end
      if (pkt_inc && !pkt_dec)      pkt_cnt_d = pkt_cnt_q + 1'b1;
      else if (pkt_dec && !pkt_inc) pkt_cnt_d = pkt_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      timer_q    <= '0;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_sop_q   <= 1'b0;
      rd_eop_q   <= 1'b0;
      overflow_q <= 1'b0;
      tflush_q   <= 1'b0;
      drop_q     <= 1'b0;
      in_pkt_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      timer_q    <= timer_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
      rd_sop_q   <= rd_sop_d;
      rd_eop_q   <= rd_eop_d;
      overflow_q <= overflow_d;
      tflush_q   <= tflush_d;
      drop_q     <= drop_d;
      in_pkt_q   <= in_pkt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q[AW-1:0]] <= {bus.wr_sop, bus.wr_eop, bus.data_in};
  end

  assign bus.full          = full;
  assign bus.almost_full   = (occupancy >= CW'(AF_THRESH));
  assign bus.overflow      = overflow_q;
  assign bus.data_out      = dout_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_sop        = rd_sop_q;
  assign bus.rd_eop        = rd_eop_q;
  assign bus.vld_out       = vld;
  assign bus.empty         = empty;
  assign bus.pkt_count     = pkt_cnt_q;
  assign bus.timeout_flush = tflush_q;
endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb/tb_router_pkt_fifo.sv - directed bench for router_pkt_fifo in cut-through and store-and-forward modes
module tb_router_pkt_fifo;
  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  logic [4:0] occ;
  logic [7:0] pw [5];

  always #5 clk = ~clk;

  router_pkt_fifo_if #(.DATA_W(8), .DEPTH(16)) i0 ();
  router_pkt_fifo_if #(.DATA_W(8), .DEPTH(16)) i1 ();

  router_pkt_fifo #(.DATA_W(8), .DEPTH(16), .MODE(0), .TIMEOUT(30), .AF_THRESH(14))
    dut0 (.clk(clk), .resetn(resetn), .bus(i0));
  router_pkt_fifo #(.DATA_W(8), .DEPTH(16), .MODE(1), .TIMEOUT(30), .AF_THRESH(14))
    dut1 (.clk(clk), .resetn(resetn), .bus(i1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    pw[0] = 8'h0C; pw[1] = 8'h11; pw[2] = 8'h22; pw[3] = 8'h33; pw[4] = 8'h5A;
    resetn = 1'b0;
    i0.soft_rst = 0; i0.write_enb = 0; i0.wr_sop = 0; i0.wr_eop = 0; i0.data_in = 0; i0.read_enb = 0;
    i1.soft_rst = 0; i1.write_enb = 0; i1.wr_sop = 0; i1.wr_eop = 0; i1.data_in = 0; i1.read_enb = 0;
    tick(); tick();
    check("rst_empty", i0.empty, 1);
    check("rst_full", i0.full, 0);
    check("rst_pkt", i0.pkt_count, 0);
    check("rst_rdv", i0.rd_valid, 0);
    check("rst_dout", i0.data_out, 0);
    check("rst_vld", i0.vld_out, 0);
    resetn = 1'b1;
    tick();

    // fill to full, then one write too many
    for (int k = 0; k < 16; k++) begin
      i0.write_enb = 1; i0.wr_sop = (k == 0); i0.wr_eop = (k == 15); i0.data_in = 8'(k + 16);
      tick();
      check($sformatf("af_%0d", k + 1), i0.almost_full, (k + 1 >= 14) ? 1 : 0);
    end
    check("fill_full", i0.full, 1);
    check("fill_pkt", i0.pkt_count, 1);
    i0.wr_sop = 0; i0.wr_eop = 0; i0.data_in = 8'hAA;
    tick();
    check("ovf_pulse", i0.overflow, 1);
    check("ovf_wrptr", dut0.wr_ptr_q, 16);
    check("ovf_full", i0.full, 1);
    i0.write_enb = 0;
    tick();
    check("ovf_clear", i0.overflow, 0);
    i0.soft_rst = 1;
    tick();
    i0.soft_rst = 0;
    check("srst_empty", i0.empty, 1);
    check("srst_pkt", i0.pkt_count, 0);

    // store-and-forward with read_enb held high
    i1.read_enb = 1;
    for (int k = 0; k < 5; k++) begin
      i1.write_enb = 1; i1.wr_sop = (k == 0); i1.wr_eop = (k == 4); i1.data_in = pw[k];
      tick();
      check($sformatf("sf_vld_%0d", k), i1.vld_out, (k == 4) ? 1 : 0);
      check($sformatf("sf_rdv_%0d", k), i1.rd_valid, 0);
    end
    i1.write_enb = 0; i1.wr_sop = 0; i1.wr_eop = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("sf_rdv_rd%0d", k), i1.rd_valid, 1);
      check($sformatf("sf_data_%0d", k), i1.data_out, pw[k]);
      check($sformatf("sf_sop_%0d", k), i1.rd_sop, (k == 0) ? 1 : 0);
      check($sformatf("sf_eop_%0d", k), i1.rd_eop, (k == 4) ? 1 : 0);
    end
    check("sf_pkt_end", i1.pkt_count, 0);
    tick();
    check("sf_rdv_idle", i1.rd_valid, 0);
    i1.read_enb = 0;

    // cut-through with read_enb high from the start
    i0.read_enb = 1;
    for (int k = 0; k < 5; k++) begin
      i0.write_enb = 1; i0.wr_sop = (k == 0); i0.wr_eop = (k == 4); i0.data_in = pw[k];
      tick();
      if (k == 0) check("ct_rdv_first", i0.rd_valid, 0);
      else check($sformatf("ct_data_%0d", k - 1), i0.data_out, pw[k - 1]);
    end
    i0.write_enb = 0; i0.wr_sop = 0; i0.wr_eop = 0;
    tick();
    check("ct_data_4", i0.data_out, pw[4]);
    check("ct_eop", i0.rd_eop, 1);
    check("ct_pkt", i0.pkt_count, 0);
    check("ct_empty", i0.empty, 1);
    i0.read_enb = 0;

    // read timeout: 30 stall cycles after the header becomes visible
    i0.write_enb = 1; i0.wr_sop = 1; i0.wr_eop = 0; i0.data_in = 8'h04;
    tick();
    i0.wr_sop = 0; i0.wr_eop = 1; i0.data_in = 8'h77;
    tick();
    i0.write_enb = 0; i0.wr_eop = 0;
    for (int n = 2; n <= 30; n++) begin
      tick();
      if (n == 29) check("to_early", i0.timeout_flush, 0);
    end
    check("to_pulse", i0.timeout_flush, 1);
    check("to_empty", i0.empty, 1);
    check("to_pkt", i0.pkt_count, 0);
    check("to_vld", i0.vld_out, 0);
    tick();
    check("to_pulse_end", i0.timeout_flush, 0);

    // mid-packet flush sets drop until the next header
    for (int k = 0; k < 3; k++) begin
      i0.write_enb = 1; i0.wr_sop = (k == 0); i0.wr_eop = 0; i0.data_in = 8'(8 + k);
      tick();
    end
    i0.write_enb = 0; i0.wr_sop = 0; i0.soft_rst = 1;
    tick();
    i0.soft_rst = 0;
    for (int k = 0; k < 3; k++) begin
      i0.write_enb = 1; i0.wr_sop = 0; i0.wr_eop = (k == 2); i0.data_in = 8'(3 + k);
      tick();
    end
    check("drop_empty", i0.empty, 1);
    check("drop_pkt", i0.pkt_count, 0);
    i0.wr_sop = 1; i0.wr_eop = 0; i0.data_in = 8'h10;
    tick();
    i0.write_enb = 0; i0.wr_sop = 0;
    occ = dut0.wr_ptr_q - dut0.rd_ptr_q;
    check("drop_occ", occ, 1);
    check("drop_not_empty", i0.empty, 0);
    i0.soft_rst = 1;
    tick();
    i0.soft_rst = 0;

    // full FIFO of single-word packets, then simultaneous write and read
    for (int k = 0; k < 16; k++) begin
      i0.write_enb = 1; i0.wr_sop = 1; i0.wr_eop = 1; i0.data_in = 8'(k);
      tick();
    end
    check("sim_full0", i0.full, 1);
    check("sim_pkt0", i0.pkt_count, 16);
    i0.read_enb = 1;
    for (int k = 0; k < 3; k++) begin
      i0.data_in = 8'(8'h40 + k);
      tick();
      check($sformatf("sim_full_%0d", k), i0.full, 1);
      check($sformatf("sim_ovf_%0d", k), i0.overflow, 0);
      check($sformatf("sim_pkt_%0d", k), i0.pkt_count, 16);
      check($sformatf("sim_data_%0d", k), i0.data_out, k);
    end
    #2;
    resetn = 1'b0;
    #1;
    check("arst_dout", i0.data_out, 0);
    check("arst_rdv", i0.rd_valid, 0);
    check("arst_full", i0.full, 0);
    check("arst_af", i0.almost_full, 0);
    check("arst_pkt", i0.pkt_count, 0);
    check("arst_vld", i0.vld_out, 0);
    check("arst_empty", i0.empty, 1);
    check("arst_sop", i0.rd_sop, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
